irq_timer_ctrl: RTL and testbench

IRQ_TIMER_CTRL -- requirements
Module: irq_timer_ctrl

---
 rtl/irq_pkg.sv | 13 +
 rtl/timer_channel.sv | 39 +++
 rtl/irq_timer_ctrl.sv | 64 ++++++
 tb/tb_irq_timer_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared mode enum, default parameters and width helpers for irq_timer_ctrl
package irq_pkg;
  typedef enum logic {MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1} mode_e;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NUM_EXT = 1;
  function automatic int num_src(input int num_ch, input int num_ext);
    return num_ch + num_ext;
  endfunction
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one periodic/one-shot counter with registered terminal-count pulse
module timer_channel import irq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_oneshot,
  output logic             hit,
  output logic             ovf
);
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;
  mode_e            mode;
  logic             armed;
  // hit is the wrap event of this edge; the top uses it to set pending alongside ovf
  assign hit = en && armed && !wr && count == limit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      limit <= '1;
      mode  <= MODE_PERIODIC;
      armed <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      ovf <= hit;
      if (wr) begin
        count <= '0;
        limit <= cfg_limit;
        mode  <= mode_e'(cfg_oneshot);
        armed <= 1'b1;
      end else if (en && armed) begin
        count <= hit ? '0 : count + WIDTH'(1);
        if (hit && mode == MODE_ONESHOT) armed <= 1'b0;
      end
    end
endmodule

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: timer channels plus synchronised external lines feeding a sticky
// pending register with fixed lowest-id-wins priority and ack-based clearing
module irq_timer_ctrl import irq_pkg::*; #(
  parameter  int NUM_CH  = DEF_NUM_CH,
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NUM_EXT = DEF_NUM_EXT,
  localparam int NUM_SRC = num_src(NUM_CH, NUM_EXT),
  localparam int ID_W    = id_w(NUM_SRC),
  localparam int CH_W    = id_w(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  timer_en,
  input  logic               cfg_wr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_oneshot,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [NUM_EXT-1:0] ext_inter,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_CH-1:0]  ovf
);
  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);
  logic [NUM_CH-1:0]  hit;
  logic [NUM_EXT-1:0] s1, s2, s3;
  logic [NUM_EXT-1:0] rise;
  logic [NUM_SRC-1:0] pending, act, clr;
  // channel indices >= NUM_CH never match a generated instance, so such writes drop
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk,
      .rst,
      .en(timer_en[c]),
      .wr(cfg_wr && cfg_ch == CH_W'(c)),
      .cfg_limit,
      .cfg_oneshot,
      .hit(hit[c]),
      .ovf(ovf[c])
    );
  end
  assign rise = s2 & ~s3;
  assign clr = (irq_ack && irq_valid) ? ONE << irq_id : '0;
  assign irq_valid = |act;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      pending <= '0;
    end else begin
      s1 <= ext_inter;
      s2 <= s1;
      s3 <= s2;
      pending <= (pending & ~clr) | {rise, hit};
    end
  always_comb begin
    act = pending & src_mask;
    irq_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (act[i]) irq_id = ID_W'(i);
  end
endmodule

// File: tb/tb_irq_timer_ctrl.sv
// tb_irq_timer_ctrl: directed checks of timers, priority, ack collisions, external sync and reset
module tb_irq_timer_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] timer_en = '0;
  logic       cfg_wr = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_limit = '0;
  logic       cfg_oneshot = 1'b0;
  logic [2:0] src_mask = 3'b111;
  logic [0:0] ext_inter = '0;
  logic       irq_ack = 1'b0;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [1:0] ovf;
  int checks = 0;
  int failures = 0;
  int n;
  always #5 clk = ~clk;
  irq_timer_ctrl dut (
    .clk(clk), .rst(rst), .timer_en(timer_en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_limit(cfg_limit), .cfg_oneshot(cfg_oneshot), .src_mask(src_mask),
    .ext_inter(ext_inter), .irq_ack(irq_ack), .irq_valid(irq_valid), .irq_id(irq_id), .ovf(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic cfg(input logic [0:0] ch, input logic [7:0] lim, input logic os);
    cfg_wr = 1'b1;
    cfg_ch = ch;
    cfg_limit = lim;
    cfg_oneshot = os;
    tick();
    cfg_wr = 1'b0;
  endtask
  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask
  initial begin
    #12;
    chk("reset_valid", irq_valid, 1'b0);
    chk("reset_id", irq_id, 2'd0);
    chk("reset_ovf", ovf, 2'b00);
    rst = 1'b1;
    timer_en = 2'b01;
    cfg(1'b0, 8'd3, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("periodic_ovf", ovf, (k % 4 == 0) ? 2'b01 : 2'b00);
    end
    chk("periodic_valid", irq_valid, 1'b1);
    chk("periodic_id", irq_id, 2'd0);
    timer_en = 2'b00;
    ack();
    chk("periodic_ack_valid", irq_valid, 1'b0);
    timer_en = 2'b01;
    tick(3);
    chk("coll_pre_valid", irq_valid, 1'b0);
    tick();
    chk("coll_first_ovf", ovf, 2'b01);
    chk("coll_first_valid", irq_valid, 1'b1);
    tick(3);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("coll_ovf", ovf, 2'b01);
    chk("coll_valid", irq_valid, 1'b1);
    chk("coll_id", irq_id, 2'd0);
    timer_en = 2'b00;
    ack();
    chk("coll_cleared", irq_valid, 1'b0);
    timer_en = 2'b10;
    cfg(1'b1, 8'd2, 1'b1);
    n = 0;
    repeat (20) begin
      tick();
      if (ovf[1]) n++;
    end
    chk("oneshot_pulses", n, 1);
    chk("oneshot_valid", irq_valid, 1'b1);
    chk("oneshot_id", irq_id, 2'd1);
    cfg(1'b1, 8'd2, 1'b1);
    n = 0;
    repeat (20) begin
      tick();
      if (ovf[1]) n++;
    end
    chk("rearm_pulses", n, 1);
    cfg(1'b1, 8'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("limit0_ovf", ovf, 2'b10);
    end
    timer_en = 2'b00;
    tick();
    chk("limit0_off", ovf, 2'b00);
    ext_inter = 1'b1;
    tick(3);
    chk("prio_valid", irq_valid, 1'b1);
    chk("prio_id1", irq_id, 2'd1);
    ack();
    chk("prio_id2", irq_id, 2'd2);
    chk("prio_valid2", irq_valid, 1'b1);
    ack();
    chk("prio_empty_valid", irq_valid, 1'b0);
    chk("prio_empty_id", irq_id, 2'd0);
    tick(5);
    chk("ext_level_once", irq_valid, 1'b0);
    ext_inter = 1'b0;
    tick(3);
    ext_inter = 1'b1;
    tick();
    chk("ext_edge1", irq_valid, 1'b0);
    tick();
    chk("ext_edge2", irq_valid, 1'b0);
    tick();
    chk("ext_edge3_valid", irq_valid, 1'b1);
    chk("ext_edge3_id", irq_id, 2'd2);
    src_mask = 3'b011;
    #1;
    chk("ext_masked_valid", irq_valid, 1'b0);
    chk("ext_masked_id", irq_id, 2'd0);
    tick(7);
    chk("ext_masked_hold", irq_valid, 1'b0);
    src_mask = 3'b111;
    #1;
    chk("ext_unmask_valid", irq_valid, 1'b1);
    chk("ext_unmask_id", irq_id, 2'd2);
    ack();
    chk("ext_ack", irq_valid, 1'b0);
    ext_inter = 1'b0;
    tick(3);
    timer_en = 2'b01;
    cfg(1'b0, 8'd3, 1'b0);
    tick(4);
    chk("rst_pre_ovf", ovf, 2'b01);
    chk("rst_pre_valid", irq_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_async_ovf", ovf, 2'b00);
    chk("rst_async_valid", irq_valid, 1'b0);
    chk("rst_async_id", irq_id, 2'd0);
    #2;
    rst = 1'b1;
    tick();
    chk("rst_post_ovf", ovf, 2'b00);
    chk("rst_post_valid", irq_valid, 1'b0);
    tick(4);
    chk("rst_disarmed_ovf", ovf, 2'b00);
    chk("rst_disarmed_valid", irq_valid, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
